// File: rtl/riscv_dift_tag_ex.sv
// EX-stage DIFT tag datapath: propagates multi-bit operand tags, registers the WB tag,
// and queues tag-check violations in a small exception FIFO drained by the controller.
module riscv_dift_tag_ex #(
    parameter int unsigned TAG_WIDTH = 4,
    parameter int unsigned EXC_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid_i,
    input  logic                 wb_ready_i,
    input  logic [1:0]           prop_mode_i,
    input  logic [TAG_WIDTH-1:0] tag_a_i,
    input  logic [TAG_WIDTH-1:0] tag_b_i,
    input  logic                 rf_we_i,
    input  logic [4:0]           rd_addr_i,
    input  logic                 set_tag_i,
    input  logic                 load_i,
    input  logic                 chk_s1_i,
    input  logic                 chk_s2_i,
    input  logic                 chk_d_i,
    input  logic [TAG_WIDTH-1:0] chk_mask_i,
    input  logic [31:0]          pc_i,
    output logic [TAG_WIDTH-1:0] res_tag_o,
    output logic [TAG_WIDTH-1:0] wb_tag_o,
    output logic                 wb_tag_we_o,
    output logic [4:0]           wb_tag_addr_o,
    output logic [TAG_WIDTH-1:0] ld_rs1_tag_o,
    output logic                 exc_valid_o,
    input  logic                 exc_ready_i,
    output logic [31:0]          exc_pc_o,
    output logic [2:0]           exc_src_o,
    output logic [TAG_WIDTH-1:0] exc_tag_o,
    output logic                 exc_ovf_o,
    input  logic                 exc_clr_i
);

    localparam int unsigned TW = TAG_WIDTH;
    localparam int unsigned PW = $clog2(EXC_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] MODE_CLEAR = 2'b00;
    localparam logic [1:0] MODE_OR    = 2'b01;
    localparam logic [1:0] MODE_AND   = 2'b10;

    logic [TW-1:0] res_tag_c;
    logic          hit_s1_c, hit_s2_c, hit_d_c, hit_c;
    logic [2:0]    hit_src_c;
    logic [TW-1:0] hit_tag_c;

    logic [TW-1:0] wb_tag_q, wb_tag_d;
    logic          wb_we_q, wb_we_d;
    logic [4:0]    wb_addr_q, wb_addr_d;
    logic [TW-1:0] ld_tag_q, ld_tag_d;

    logic [31:0]   pc_mem_q  [EXC_DEPTH];
    logic [2:0]    src_mem_q [EXC_DEPTH];
    logic [TW-1:0] tag_mem_q [EXC_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full_c, do_push_c, do_pop_c, drop_c;

    // Result tag: tag-set instructions override the propagation mode
    always_comb begin
        res_tag_c = '0;
        if (set_tag_i) begin
            res_tag_c = '1;
        end else begin
            case (prop_mode_i)
                MODE_CLEAR: res_tag_c = '0;
                MODE_OR:    res_tag_c = tag_a_i | tag_b_i;
                MODE_AND:   res_tag_c = tag_a_i & tag_b_i;
                default:    res_tag_c = tag_a_i;
            endcase
        end
    end

    assign res_tag_o = res_tag_c;

    assign hit_s1_c  = ex_valid_i & chk_s1_i & (|(tag_a_i & chk_mask_i));
    assign hit_s2_c  = ex_valid_i & chk_s2_i & (|(tag_b_i & chk_mask_i));
    assign hit_d_c   = ex_valid_i & chk_d_i  & (|(res_tag_c & chk_mask_i));
    assign hit_src_c = {hit_d_c, hit_s2_c, hit_s1_c};
    assign hit_c     = |hit_src_c;
    assign hit_tag_c = ({TW{hit_s1_c}} & tag_a_i   & chk_mask_i)
                     | ({TW{hit_s2_c}} & tag_b_i   & chk_mask_i)
                     | ({TW{hit_d_c}}  & res_tag_c & chk_mask_i);

    // WB pipeline register and last-load rs1 tag
    always_comb begin
        wb_tag_d  = wb_tag_q;
        wb_we_d   = wb_we_q;
        wb_addr_d = wb_addr_q;
        ld_tag_d  = ld_tag_q;
        if (ex_valid_i) begin
            wb_we_d = rf_we_i;
            if (rf_we_i) begin
                wb_tag_d  = res_tag_c;
                wb_addr_d = rd_addr_i;
            end
            if (load_i) begin
                ld_tag_d = tag_a_i;
            end
        end else if (wb_ready_i) begin
            wb_we_d = 1'b0;
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
    always_comb begin
        full_c    = (count_q == CW'(EXC_DEPTH));
        do_pop_c  = exc_valid_o & exc_ready_i;
        do_push_c = hit_c & (~full_c | do_pop_c);
        drop_c    = hit_c & full_c & ~do_pop_c;
        wr_ptr_d  = do_push_c ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d  = do_pop_c  ? PW'(rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d   = count_q;
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = CW'(count_q + 1'b1);
            2'b01:   count_d = CW'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (drop_c) begin
            ovf_d = 1'b1;
        end else if (exc_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_tag_q  <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            ld_tag_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wb_tag_q  <= wb_tag_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            ld_tag_q  <= ld_tag_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // Entry storage needs no reset: the count gates every read
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            pc_mem_q[wr_ptr_q]  <= pc_i;
            src_mem_q[wr_ptr_q] <= hit_src_c;
            tag_mem_q[wr_ptr_q] <= hit_tag_c;
        end
    end

    assign wb_tag_o      = wb_tag_q;
    assign wb_tag_we_o   = wb_we_q;
    assign wb_tag_addr_o = wb_addr_q;
    assign ld_rs1_tag_o  = ld_tag_q;
    assign exc_valid_o   = (count_q != '0);
    assign exc_pc_o      = pc_mem_q[rd_ptr_q];
    assign exc_src_o     = src_mem_q[rd_ptr_q];
    assign exc_tag_o     = tag_mem_q[rd_ptr_q];
    assign exc_ovf_o     = ovf_q;

endmodule
